// File: rtl/demux_stream_pkg.sv
// demux_stream_pkg: shared FSM state type and statistics constants for demux_stream.
package demux_stream_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int unsigned     STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/demux_onehot.sv
// demux_onehot: combinational select-to-one-hot decoder with enable.
// Output is all-zero when disabled or when sel addresses a non-existent channel.
module demux_onehot #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  output logic [CHANNELS-1:0] onehot
);

  // Only channels 0..CHANNELS-1 can match, so out-of-range selects decode to zero.
  always_comb begin
    onehot = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (en && (sel == SEL_W'(k))) begin
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-CHANNELS stream demultiplexer with valid/ready
// handshaking, sticky illegal-select flag and optional per-channel delivery
// counters (enabled by defining DEMUX_STREAM_STATS_EN).
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 8,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [SEL_W-1:0]           in_sel,
  output logic [CHANNELS-1:0]        out_valid,
  input  logic [CHANNELS-1:0]        out_ready,
  output logic [WIDTH-1:0]           out_data,
`ifdef DEMUX_STREAM_STATS_EN
  output logic                       sel_err,
  input  logic                       stat_clr,
  output logic [CHANNELS*STAT_W-1:0] stat_cnt
`else
  output logic                       sel_err
`endif
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 sel_err_q, sel_err_d;

  logic [CHANNELS-1:0]  in_dec;
  logic [CHANNELS-1:0]  out_fire_vec;
  logic                 sel_legal;
  logic                 in_fire;
  logic                 out_fire;

  // Legality of the offered select: an out-of-range select decodes to all-zero.
  demux_onehot #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_in_dec (
    .en     (1'b1),
    .sel    (in_sel),
    .onehot (in_dec)
  );

  // Output valid vector: one-hot of the held select while a beat is held.
  demux_onehot #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_out_dec (
    .en     (state_q == ST_FULL),
    .sel    (sel_q),
    .onehot (out_valid)
  );

  // Handshake qualifiers; out_fire equals out_ready[sel_q] while FULL.
  always_comb begin
    sel_legal    = |in_dec;
    out_fire_vec = out_valid & out_ready;
    out_fire     = |out_fire_vec;
    in_ready     = (state_q == ST_EMPTY) || out_fire;
    in_fire      = in_valid && in_ready;
  end

  // Next-state: capture legal beats, drain on output transfer, flag illegal selects.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    sel_d     = sel_q;
    sel_err_d = sel_err_q;
    if (in_fire && !sel_legal) begin
      sel_err_d = 1'b1;
    end
    case (state_q)
      ST_EMPTY: begin
        if (in_fire && sel_legal) begin
          state_d = ST_FULL;
          data_d  = in_data;
          sel_d   = in_sel;
        end
      end
      ST_FULL: begin
        // in_fire implies out_fire here, so a legal input replaces the held beat.
        if (in_fire && sel_legal) begin
          data_d = in_data;
          sel_d  = in_sel;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and datapath registers; reset drops any held beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      data_q    <= '0;
      sel_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_data = data_q;
  assign sel_err  = sel_err_q;

`ifdef DEMUX_STREAM_STATS_EN
  logic [CHANNELS-1:0][STAT_W-1:0] cnt_q, cnt_d;

  // Per-channel delivery counters: saturate at STAT_MAX, clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (stat_clr) begin
        cnt_d[k] = '0;
      end else if (out_fire_vec[k] && (cnt_q[k] != STAT_MAX)) begin
        cnt_d[k] = cnt_q[k] + STAT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: self-checking bench for demux_stream (8-channel main instance,
// 6-channel instance for out-of-range selects). Counter checks are compiled when
// DEMUX_STREAM_STATS_EN is defined.
module tb_demux_stream;

  logic       clk;
  logic       rst_n;

  // Main instance: WIDTH=8, CHANNELS=8
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [7:0] out_data;
  logic       sel_err;

  // Second instance: WIDTH=8, CHANNELS=6
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_in_data;
  logic [2:0] b_in_sel;
  logic [5:0] b_out_valid;
  logic [5:0] b_out_ready;
  logic [7:0] b_out_data;
  logic       b_sel_err;

`ifdef DEMUX_STREAM_STATS_EN
  logic         stat_clr;
  logic         clr_req;
  logic [127:0] stat_cnt;
  logic         b_stat_clr;
  logic [95:0]  b_stat_cnt;
`endif

  int n_chk;
  int n_fail;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];

  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] rdy;
    logic       exp_ir;
    logic [7:0] exp_ov;
    logic [7:0] exp_od;
  } vec_t;

  vec_t tbl[11];

  demux_stream #(
    .WIDTH    (8),
    .CHANNELS (8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef DEMUX_STREAM_STATS_EN
    .sel_err   (sel_err),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`else
    .sel_err   (sel_err)
`endif
  );

  demux_stream #(
    .WIDTH    (8),
    .CHANNELS (6)
  ) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
`ifdef DEMUX_STREAM_STATS_EN
    .sel_err   (b_sel_err),
    .stat_clr  (b_stat_clr),
    .stat_cnt  (b_stat_cnt)
`else
    .sel_err   (b_sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle on the main instance: drive at negedge, check against the
  // scoreboard, then update the scoreboard for the coming rising edge.
  task automatic cyc(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [7:0] r);
    logic       exp_ir;
    logic [7:0] exp_ov;
    beat_t      nb;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
`ifdef DEMUX_STREAM_STATS_EN
    stat_clr  = clr_req;
`endif
    #1;
    exp_ir = (sb.size() == 0) || r[sb[0].sel];
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    if (sb.size() > 0) begin
      exp_ov = 8'd1 << sb[0].sel;
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("out_data", 64'(out_data), 64'(sb[0].data));
    end else begin
      chk("out_valid_idle", 64'(out_valid), 64'(0));
    end
    chk("sel_err_main", 64'(sel_err), 64'(0));
    if (sb.size() > 0 && r[sb[0].sel]) begin
      void'(sb.pop_front());
    end
    if (v && exp_ir) begin
      nb.sel  = s;
      nb.data = d;
      sb.push_back(nb);
    end
  endtask

`ifdef DEMUX_STREAM_STATS_EN
  task automatic chk_cnt(input string name, input int unsigned ch, input logic [15:0] exp);
    logic [127:0] all;
    logic [15:0]  v;
    all = stat_cnt;
    v   = all[ch*16 +: 16];
    chk(name, 64'(v), 64'(exp));
  endtask
`endif

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sel      = '0;
    in_data     = '0;
    out_ready   = '1;
    b_in_valid  = 1'b0;
    b_in_sel    = '0;
    b_in_data   = '0;
    b_out_ready = '1;
`ifdef DEMUX_STREAM_STATS_EN
    stat_clr    = 1'b0;
    clr_req     = 1'b0;
    b_stat_clr  = 1'b0;
`endif

    //            v     sel   data   rdy    ir    ov     od
    tbl[0]  = '{1'b1, 3'd5, 8'hA5, 8'hFF, 1'b1, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h20, 8'hA5};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 3'd2, 8'h3C, 8'hFB, 1'b1, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 3'd6, 8'h77, 8'hFB, 1'b0, 8'h04, 8'h3C};
    tbl[5]  = '{1'b1, 3'd6, 8'h77, 8'hFB, 1'b0, 8'h04, 8'h3C};
    tbl[6]  = '{1'b1, 3'd6, 8'h77, 8'hFB, 1'b0, 8'h04, 8'h3C};
    tbl[7]  = '{1'b1, 3'd6, 8'h77, 8'hFB, 1'b0, 8'h04, 8'h3C};
    tbl[8]  = '{1'b1, 3'd6, 8'h77, 8'hFF, 1'b1, 8'h04, 8'h3C};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h40, 8'h77};
    tbl[10] = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00};

    // Reset for three cycles, then release
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_sel_err", 64'(sel_err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
`ifdef DEMUX_STREAM_STATS_EN
    chk("rst_stat_cnt", 64'(stat_cnt[63:0] | stat_cnt[127:64]), 64'(0));
`endif

    // Table: single beat, then backpressure on channel 2 with hand-off
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].rdy);
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].exp_ir));
      chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov != 8'h00) begin
        chk("tbl_out_data", 64'(out_data), 64'(tbl[i].exp_od));
      end
    end

    // Streaming sweep across all channels, no idle gaps
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'(i), 8'(8'h10 * i + 1), 8'hFF);
      chk("sweep_in_ready", 64'(in_ready), 64'(1));
      if (i > 0) begin
        chk("sweep_walk", 64'(out_valid), 64'(8'd1 << (i - 1)));
      end
    end
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    chk("sweep_last", 64'(out_valid), 64'(8'h80));
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);

    // Out-of-range selects on the 6-channel instance
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_sel   = 3'd7;
    b_in_data  = 8'h5A;
    #1;
    chk("b_ir_illegal", 64'(b_in_ready), 64'(1));
    chk("b_err_pre", 64'(b_sel_err), 64'(0));
    @(negedge clk);
    b_in_sel  = 3'd3;
    b_in_data = 8'h33;
    #1;
    chk("b_ov_discard", 64'(b_out_valid), 64'(0));
    chk("b_err_set", 64'(b_sel_err), 64'(1));
    chk("b_ir_empty", 64'(b_in_ready), 64'(1));
    @(negedge clk);
    b_in_sel = 3'd6;
    #1;
    chk("b_ov_legal", 64'(b_out_valid), 64'(6'b001000));
    chk("b_od_legal", 64'(b_out_data), 64'(8'h33));
    chk("b_ir_full", 64'(b_in_ready), 64'(1));
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("b_ov_full_illegal", 64'(b_out_valid), 64'(0));
    chk("b_err_sticky", 64'(b_sel_err), 64'(1));
    @(negedge clk);
    #1;
    chk("b_err_sticky2", 64'(b_sel_err), 64'(1));

`ifdef DEMUX_STREAM_STATS_EN
    // Counters: clear, deliver 3 beats to ch1 and 1 to ch4
    clr_req = 1'b1;
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    clr_req = 1'b0;
    cyc(1'b1, 3'd1, 8'h11, 8'hFF);
    cyc(1'b1, 3'd1, 8'h12, 8'hFF);
    cyc(1'b1, 3'd1, 8'h13, 8'hFF);
    cyc(1'b1, 3'd4, 8'h44, 8'hFF);
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    for (int unsigned k = 0; k < 8; k++) begin
      chk_cnt("stat_count", k, (k == 1) ? 16'd3 : ((k == 4) ? 16'd1 : 16'd0));
    end
    clr_req = 1'b1;
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    clr_req = 1'b0;
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    chk("stat_cleared", 64'(stat_cnt[63:0] | stat_cnt[127:64]), 64'(0));

    // Clear wins over a same-cycle increment
    cyc(1'b1, 3'd1, 8'h21, 8'hFF);
    clr_req = 1'b1;
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    clr_req = 1'b0;
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    chk_cnt("stat_clr_wins", 1, 16'd0);

    // Saturation on channel 0
    for (int i = 0; i < 65535; i++) begin
      cyc(1'b1, 3'd0, 8'(i), 8'hFF);
    end
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    chk_cnt("stat_reach_max", 0, 16'hFFFF);
    cyc(1'b1, 3'd0, 8'hEE, 8'hFF);
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    chk_cnt("stat_saturate", 0, 16'hFFFF);
    chk_cnt("stat_other", 1, 16'd0);
`endif

    // Asynchronous reset while a beat is held under backpressure
    cyc(1'b1, 3'd2, 8'h9C, 8'hFB);
    cyc(1'b0, 3'd0, 8'h00, 8'hFB);
    chk("hold_before_rst", 64'(out_valid), 64'(8'h04));
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("async_rst_ov", 64'(out_valid), 64'(0));
    chk("async_rst_od", 64'(out_data), 64'(0));
    chk("async_rst_ir", 64'(in_ready), 64'(1));
    chk("async_rst_b_err", 64'(b_sel_err), 64'(0));
`ifdef DEMUX_STREAM_STATS_EN
    chk("async_rst_stat", 64'(stat_cnt[63:0] | stat_cnt[127:64]), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Traffic resumes after reset
    cyc(1'b1, 3'd7, 8'hC3, 8'hFF);
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);
    chk("post_rst_ov", 64'(out_valid), 64'(8'h80));
    cyc(1'b0, 3'd0, 8'h00, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
